// File: rtl/mult_div_if.sv
// Handshake and result bundle between the execute stage and the iterative
// multiply/divide unit.
interface mult_div_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// Operates on magnitudes and applies result signs once, in the FINISH cycle.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    mult_div_if.slave    bus
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE_ITER  = CW'(1);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t               state, state_next;
    logic [CW-1:0]        iter;
    logic                 is_div, neg_lo, neg_hi, zero_div;
    logic [WIDTH-1:0]     opnd, a_raw;
    logic [2*WIDTH-1:0]   acc, acc_step, prod_s;
    logic [WIDTH:0]       mul_sum, div_trial;
    logic [WIDTH-1:0]     mag_a, mag_b, hi_res, lo_res, quo, rem;
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic                 done_q, dbz_q;
    logic                 sign_a, sign_b, launch, busy_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = CALC;
            CALC:    if (iter == LAST_ITER) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_c = (state != IDLE);
        launch = (state == IDLE) && bus.start;
    end

    always_comb begin
        sign_a = bus.op[0] & bus.src_a[WIDTH-1];
        sign_b = bus.op[0] & bus.src_b[WIDTH-1];
        mag_a  = sign_a ? -bus.src_a : bus.src_a;
        mag_b  = sign_b ? -bus.src_b : bus.src_b;
    end

    // acc holds {partial product, remaining multiplier} for multiply and
    // {partial remainder, remaining dividend / quotient bits} for divide.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
        if (!is_div)
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        else if (div_trial[WIDTH])
            acc_step = {acc[2*WIDTH-2:0], 1'b0};
        else
            acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    always_comb begin
        prod_s = neg_lo ? -acc : acc;
        quo    = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem    = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (zero_div) begin
            hi_res = a_raw;
            lo_res = '1;
        end else if (is_div) begin
            hi_res = rem;
            lo_res = quo;
        end else begin
            hi_res = prod_s[2*WIDTH-1:WIDTH];
            lo_res = prod_s[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter     <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            zero_div <= 1'b0;
            opnd     <= '0;
            a_raw    <= '0;
            acc      <= '0;
        end else if (launch) begin
            iter     <= '0;
            is_div   <= bus.op[1];
            neg_lo   <= sign_a ^ sign_b;
            neg_hi   <= sign_a;
            zero_div <= bus.op[1] && (bus.src_b == '0);
            opnd     <= bus.op[1] ? mag_b : mag_a;
            a_raw    <= bus.src_a;
            acc      <= {{WIDTH{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
        end else if (state == CALC) begin
            iter <= iter + ONE_ITER;
            acc  <= acc_step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            done_q <= (state == FINISH);
            dbz_q  <= (state == FINISH) && zero_div;
            if (state == FINISH) begin
                hi_q <= hi_res;
                lo_q <= lo_res;
            end else if (state == IDLE && !bus.start) begin
                if (bus.hi_we) hi_q <= bus.wdata;
                if (bus.lo_we) lo_q <= bus.wdata;
            end
        end
    end

    assign bus.busy        = busy_c;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios plus random ops
// compared against a 64-bit arithmetic reference of MULT/DIV semantics.
module tb_mult_div_unit;
    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] model_hi, model_lo;
    logic [63:0] pend_res;
    logic        pend_dbz;

    mult_div_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns {HI, LO} as the architecture defines them.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 2'd0)
            res = {32'b0, a} * {32'b0, b};
        else if (op == 2'd1)
            res = 64'(sa * sb);
        else if (b == 32'd0)
            res = {a, 32'hFFFF_FFFF};
        else if (op == 2'd2)
            res = {a % b, a / b};
        else begin
            q   = sa / sb;
            r   = sa % sb;
            res = {r[31:0], q[31:0]};
        end
        return res;
    endfunction

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic with_hi_we);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        bus.hi_we = with_hi_we;
        bus.wdata = 32'hDEAD_BEEF;
        pend_res  = ref_result(op, a, b);
        pend_dbz  = op[1] && (b == 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
    endtask

    // poke: 0 none, 1 start pulse mid-CALC, 2 lo_we pulse mid-CALC
    task automatic wait_done(input string tag, input int poke);
        int cycles    = 0;
        bit hold_bad  = 0;
        bit dbz_early = 0;
        bit busy_bad  = 0;
        while (!bus.done && cycles < 40) begin
            if (bus.hi !== model_hi || bus.lo !== model_lo) hold_bad = 1;
            if (bus.div_by_zero) dbz_early = 1;
            if (!bus.busy) busy_bad = 1;
            if (poke == 1 && cycles == 5) begin
                bus.start = 1'b1;
                bus.op    = 2'd0;
                bus.src_a = $urandom;
                bus.src_b = $urandom;
            end
            if (poke == 2 && cycles == 5) begin
                bus.lo_we = 1'b1;
                bus.wdata = $urandom;
            end
            @(negedge clk);
            bus.start = 1'b0;
            bus.lo_we = 1'b0;
            cycles++;
        end
        check({tag, ".busy_cycles"}, 64'(cycles), 64'd33);
        check({tag, ".busy_gap"}, 64'(busy_bad), 64'd0);
        check({tag, ".hold"}, 64'(hold_bad), 64'd0);
        check({tag, ".dbz_early"}, 64'(dbz_early), 64'd0);
        check({tag, ".busy_at_done"}, 64'(bus.busy), 64'd0);
        check({tag, ".hi"}, 64'(bus.hi), 64'(pend_res[63:32]));
        check({tag, ".lo"}, 64'(bus.lo), 64'(pend_res[31:0]));
        check({tag, ".dbz"}, 64'(bus.div_by_zero), 64'(pend_dbz));
        model_hi = pend_res[63:32];
        model_lo = pend_res[31:0];
    endtask

    task automatic after_done(input string tag);
        @(negedge clk);
        check({tag, ".done_1cyc"}, 64'(bus.done), 64'd0);
        check({tag, ".dbz_1cyc"}, 64'(bus.div_by_zero), 64'd0);
    endtask

    task automatic mt_write(input string tag, input logic hw, input logic lw, input logic [31:0] d);
        bus.hi_we = hw;
        bus.lo_we = lw;
        bus.wdata = d;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        if (hw) model_hi = d;
        if (lw) model_lo = d;
        check({tag, ".hi"}, 64'(bus.hi), 64'(model_hi));
        check({tag, ".lo"}, 64'(bus.lo), 64'(model_lo));
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        bit          late_done;

        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.src_a = '0;
        bus.src_b = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        model_hi  = '0;
        model_lo  = '0;
        rst_n     = 1'b0;
        #22;
        check("reset.busy", 64'(bus.busy), 64'd0);
        check("reset.done", 64'(bus.done), 64'd0);
        check("reset.dbz", 64'(bus.div_by_zero), 64'd0);
        check("reset.hi", 64'(bus.hi), 64'd0);
        check("reset.lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        launch(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done("multu_max", 0);
        check("multu_max.hi_const", 64'(bus.hi), 64'hFFFF_FFFE);
        after_done("multu_max");

        launch(2'd1, 32'hFFFF_FFFD, 32'd7, 1'b0);
        wait_done("mult_neg", 0);
        check("mult_neg.lo_const", 64'(bus.lo), 64'hFFFF_FFEB);
        after_done("mult_neg");

        launch(2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_done("div_neg", 0);
        launch(2'd2, 32'd7, 32'd2, 1'b0);
        wait_done("divu_b2b", 0);
        check("divu_b2b.lo_const", 64'(bus.lo), 64'd3);
        after_done("divu_b2b");

        launch(2'd2, 32'd5, 32'd0, 1'b0);
        wait_done("divu_zero", 0);
        after_done("divu_zero");

        launch(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_done("div_ovf", 0);
        after_done("div_ovf");

        mt_write("mthi", 1'b1, 1'b0, 32'h1234_5678);
        mt_write("mthilo", 1'b1, 1'b1, 32'hCAFE_F00D);

        launch(2'd0, 32'd9, 32'd11, 1'b0);
        wait_done("lo_we_busy", 2);
        after_done("lo_we_busy");

        launch(2'd1, 32'h0001_0000, 32'hFFFF_0000, 1'b1);
        wait_done("start_hi_we", 0);
        after_done("start_hi_we");

        launch(2'd2, 32'd1000, 32'd7, 1'b0);
        wait_done("start_ignored", 1);
        late_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) late_done = 1;
        end
        check("start_ignored.single_done", 64'(late_done), 64'd0);

        launch(2'd0, 32'h1357_9BDF, 32'h2468_ACE0, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort.busy", 64'(bus.busy), 64'd0);
        check("abort.done", 64'(bus.done), 64'd0);
        check("abort.hi", 64'(bus.hi), 64'd0);
        check("abort.lo", 64'(bus.lo), 64'd0);
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        late_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done || bus.busy) late_done = 1;
        end
        check("abort.no_done", 64'(late_done), 64'd0);
        launch(2'd0, 32'd2, 32'd3, 1'b0);
        wait_done("after_abort", 0);
        after_done("after_abort");

        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 5) == 0) b = 32'd0;
            else if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
            else if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
            if ($urandom_range(0, 3) == 0)
                mt_write($sformatf("rnd%0d.mt", i), 1'($urandom), 1'($urandom), $urandom);
            launch(op, a, b, 1'b0);
            wait_done($sformatf("rnd%0d.op%0d", i, op), 0);
            if ($urandom_range(0, 1) == 0) after_done($sformatf("rnd%0d", i));
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
